// File: rtl/sync_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_counter_pkg
//  Purpose  : Types and default constants shared by the sync_counter family
//             (the counter generator and its stream checker).
//  Contents : chk_state_t - checker state (IDLE, SYNC, LOCK)
//             CNT_W       - default observed counter width
//             STAT_W      - default statistic counter width
//  Revision : 1.0 - initial release
// ============================================================================
package sync_counter_pkg;

    localparam int CNT_W  = 4;
    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } chk_state_t;

endpackage : sync_counter_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Saturating up-counter with synchronous clear. An increment in
//             the same cycle as a clear wins and loads 1.
//  Ports    : clk  in  1  rising-edge clock
//             rst  in  1  synchronous active-high reset
//             inc  in  1  increment request
//             clr  in  1  synchronous clear
//             cnt  out W  current count, sticks at 2^W-1
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] c_MAX = '1;
    localparam logic [W-1:0] c_ONE = W'(1);

    logic [W-1:0] r_cnt_q;
    logic [W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (inc) begin
            // A coincident clear discards history; this event becomes the first.
            if (clr) begin
                w_cnt_d = c_ONE;
            end else if (r_cnt_q != c_MAX) begin
                w_cnt_d = r_cnt_q + c_ONE;
            end
        end else if (clr) begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign cnt = r_cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/sync_counter_checker.sv
`default_nettype none
// ============================================================================
//  Module   : sync_counter_checker
//  Purpose  : Monitors a free-running counter stream, locks onto the
//             increment-by-one sequence and flags every break once locked.
//             Keeps saturating error and clean-wrap statistics.
//  Ports    : clk       in  1       rising-edge clock
//             rst       in  1       synchronous active-high reset
//             en        in  1       cnt_in valid this cycle; low holds all
//             cnt_in    in  WIDTH   observed counter value
//             clr_stat  in  1       clear err_cnt / wrap_cnt (when en)
//             locked    out 1       high while in LOCK
//             err_pulse out 1       one-cycle pulse per error seen in LOCK
//             expected  out WIDTH   next value the checker expects
//             err_cnt   out STAT_W  saturating error count
//             wrap_cnt  out STAT_W  saturating count of clean wraps in LOCK
//  Revision : 1.0 - initial release
// ============================================================================
module sync_counter_checker #(
    parameter int WIDTH    = sync_counter_pkg::CNT_W,
    parameter int LOCK_CNT = 2,
    parameter int STAT_W   = sync_counter_pkg::STAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clr_stat,
    output logic              locked,
    output logic              err_pulse,
    output logic [WIDTH-1:0]  expected,
    output logic [STAT_W-1:0] err_cnt,
    output logic [STAT_W-1:0] wrap_cnt
);

    import sync_counter_pkg::*;

    // Enough bits to hold 0..LOCK_CNT inclusive.
    localparam int                 c_RUN_W    = $clog2(LOCK_CNT + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE  = c_RUN_W'(1);
    localparam logic [c_RUN_W-1:0] c_RUN_LOCK = c_RUN_W'(LOCK_CNT);
    localparam logic [WIDTH-1:0]   c_CNT_ONE  = WIDTH'(1);

    chk_state_t         r_state_q;
    chk_state_t         w_state_d;
    logic [c_RUN_W-1:0] r_run_q;
    logic [c_RUN_W-1:0] w_run_d;
    logic [WIDTH-1:0]   r_expected_q;
    logic [WIDTH-1:0]   w_expected_d;
    logic               r_locked_q;
    logic               w_locked_d;
    logic               r_err_pulse_q;
    logic               w_err_pulse_d;

    logic               w_match;
    logic [WIDTH-1:0]   w_next_exp;
    logic [c_RUN_W-1:0] w_run_inc;
    logic               w_err_inc;
    logic               w_wrap_inc;
    logic               w_stat_clr;

    assign w_match    = (cnt_in == r_expected_q);
    // Modulo 2^WIDTH by truncation: the all-ones value is followed by zero.
    assign w_next_exp = cnt_in + c_CNT_ONE;
    assign w_run_inc  = r_run_q + c_RUN_ONE;
    // Statistics hold while the stream is idle, including against clears.
    assign w_stat_clr = en & clr_stat;

    always_comb begin
        w_state_d     = r_state_q;
        w_run_d       = r_run_q;
        w_expected_d  = r_expected_q;
        w_err_pulse_d = 1'b0;
        w_err_inc     = 1'b0;
        w_wrap_inc    = 1'b0;

        if (en) begin
            // Every sampled value re-seeds the prediction, match or not.
            w_expected_d = w_next_exp;
            unique case (r_state_q)
                IDLE: begin
                    w_run_d   = '0;
                    w_state_d = SYNC;
                end
                SYNC: begin
                    if (w_match) begin
                        w_run_d = w_run_inc;
                        if (w_run_inc == c_RUN_LOCK) begin
                            w_state_d = LOCK;
                        end
                    end else begin
                        w_run_d = '0;
                    end
                end
                LOCK: begin
                    if (w_match) begin
                        // A matching zero can only follow the all-ones value.
                        w_wrap_inc = (cnt_in == '0);
                    end else begin
                        w_err_pulse_d = 1'b1;
                        w_err_inc     = 1'b1;
                        w_run_d       = '0;
                        w_state_d     = SYNC;
                    end
                end
                default: begin
                    w_run_d   = '0;
                    w_state_d = IDLE;
                end
            endcase
        end

        w_locked_d = (w_state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_run_q       <= '0;
            r_expected_q  <= '0;
            r_locked_q    <= 1'b0;
            r_err_pulse_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_run_q       <= w_run_d;
            r_expected_q  <= w_expected_d;
            r_locked_q    <= w_locked_d;
            r_err_pulse_q <= w_err_pulse_d;
        end
    end

    sat_counter #(
        .W   (STAT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_err_inc),
        .clr (w_stat_clr),
        .cnt (err_cnt)
    );

    sat_counter #(
        .W   (STAT_W)
    ) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_wrap_inc),
        .clr (w_stat_clr),
        .cnt (wrap_cnt)
    );

    assign locked    = r_locked_q;
    assign err_pulse = r_err_pulse_q;
    assign expected  = r_expected_q;

endmodule : sync_counter_checker
`default_nettype wire

// File: tb/tb_sync_counter_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_counter_checker
//  Purpose  : Self-checking bench for sync_counter_checker. Two instances
//             share stimulus: default statistics width and a 2-bit one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_counter_checker;

    localparam int c_W       = 4;
    localparam int c_MOD     = 16;
    localparam int c_LOCK    = 2;
    localparam int c_MAX8    = 255;
    localparam int c_MAX2    = 3;

    logic           clk;
    logic           rst;
    logic           en;
    logic [c_W-1:0] cnt_in;
    logic           clr_stat;

    logic           locked,    locked_s;
    logic           err_pulse, err_pulse_s;
    logic [c_W-1:0] expected,  expected_s;
    logic [7:0]     err_cnt,   wrap_cnt;
    logic [1:0]     err_cnt_s, wrap_cnt_s;

    sync_counter_checker #(.WIDTH(c_W), .LOCK_CNT(c_LOCK), .STAT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr_stat(clr_stat),
        .locked(locked), .err_pulse(err_pulse), .expected(expected),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    sync_counter_checker #(.WIDTH(c_W), .LOCK_CNT(c_LOCK), .STAT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr_stat(clr_stat),
        .locked(locked_s), .err_pulse(err_pulse_s), .expected(expected_s),
        .err_cnt(err_cnt_s), .wrap_cnt(wrap_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: history of the sampled stream since reset.
    bit m_have;     // at least one sample taken since reset
    int m_prev;     // last sampled value
    int m_streak;   // consecutive +1 steps since the last break
    bit m_locked;
    bit m_pulse;
    int m_err, m_wrap, m_err_s, m_wrap_s;

    function automatic int m_expected();
        return m_have ? (m_prev + 1) % c_MOD : 0;
    endfunction

    function automatic int stat_next(int v, bit inc, bit clr, int maxv);
        if (inc) return clr ? 1 : ((v < maxv) ? v + 1 : v);
        if (clr) return 0;
        return v;
    endfunction

    task automatic model_update(input bit r, input bit e, input bit c, input int v);
        bit err_ev, wrap_ev;
        err_ev  = 1'b0;
        wrap_ev = 1'b0;
        if (r) begin
            m_have = 0; m_prev = 0; m_streak = 0; m_locked = 0; m_pulse = 0;
            m_err = 0; m_wrap = 0; m_err_s = 0; m_wrap_s = 0;
            return;
        end
        m_pulse = 0;
        if (!e) return;
        if (!m_have) begin
            m_have   = 1;
            m_streak = 0;
        end else if (v == (m_prev + 1) % c_MOD) begin
            if (m_locked) begin
                wrap_ev = (v == 0);
            end else begin
                m_streak++;
                if (m_streak >= c_LOCK) m_locked = 1;
            end
        end else begin
            if (m_locked) err_ev = 1'b1;
            m_locked = 0;
            m_streak = 0;
        end
        m_prev   = v;
        m_pulse  = err_ev;
        m_err    = stat_next(m_err,    err_ev,  c, c_MAX8);
        m_wrap   = stat_next(m_wrap,   wrap_ev, c, c_MAX8);
        m_err_s  = stat_next(m_err_s,  err_ev,  c, c_MAX2);
        m_wrap_s = stat_next(m_wrap_s, wrap_ev, c, c_MAX2);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".locked"},      int'(locked),      int'(m_locked));
        chk({tag, ".err_pulse"},   int'(err_pulse),   int'(m_pulse));
        chk({tag, ".expected"},    int'(expected),    m_expected());
        chk({tag, ".err_cnt"},     int'(err_cnt),     m_err);
        chk({tag, ".wrap_cnt"},    int'(wrap_cnt),    m_wrap);
        chk({tag, ".locked_s"},    int'(locked_s),    int'(m_locked));
        chk({tag, ".err_pulse_s"}, int'(err_pulse_s), int'(m_pulse));
        chk({tag, ".expected_s"},  int'(expected_s),  m_expected());
        chk({tag, ".err_cnt_s"},   int'(err_cnt_s),   m_err_s);
        chk({tag, ".wrap_cnt_s"},  int'(wrap_cnt_s),  m_wrap_s);
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input bit r, input bit e, input bit c, input int v);
        rst      = r;
        en       = e;
        clr_stat = c;
        cnt_in   = c_W'(v);
        model_update(r, e, c, v % c_MOD);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rst; bit en; bit clr; int cnt;
        int e_locked; int e_pulse; int e_exp; int e_err; int e_wrap;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int v;
        rst = 1'b1; en = 1'b0; clr_stat = 1'b0; cnt_in = '0;
        model_update(1, 0, 0, 0);

        // Reset, lock on 0..3, glitch at 9, relock, clean wrap 15 -> 0.
        tbl[0]  = '{1, 0, 0,  0,   0, 0,  0, 0, 0};
        tbl[1]  = '{1, 0, 0,  0,   0, 0,  0, 0, 0};
        tbl[2]  = '{0, 1, 0,  0,   0, 0,  1, 0, 0};
        tbl[3]  = '{0, 1, 0,  1,   0, 0,  2, 0, 0};
        tbl[4]  = '{0, 1, 0,  2,   1, 0,  3, 0, 0};
        tbl[5]  = '{0, 1, 0,  3,   1, 0,  4, 0, 0};
        tbl[6]  = '{0, 1, 0,  4,   1, 0,  5, 0, 0};
        tbl[7]  = '{0, 1, 0,  9,   0, 1, 10, 1, 0};
        tbl[8]  = '{0, 1, 0, 10,   0, 0, 11, 1, 0};
        tbl[9]  = '{0, 1, 0, 11,   1, 0, 12, 1, 0};
        tbl[10] = '{0, 1, 0, 12,   1, 0, 13, 1, 0};
        tbl[11] = '{0, 1, 0, 13,   1, 0, 14, 1, 0};
        tbl[12] = '{0, 1, 0, 14,   1, 0, 15, 1, 0};
        tbl[13] = '{0, 1, 0, 15,   1, 0,  0, 1, 0};
        tbl[14] = '{0, 1, 0,  0,   1, 0,  1, 1, 1};
        tbl[15] = '{0, 1, 0,  1,   1, 0,  2, 1, 1};

        for (int i = 0; i < 16; i++) begin
            string tg;
            step(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].cnt);
            tg = $sformatf("vec%0d", i);
            chk({tg, ".locked"},    int'(locked),    tbl[i].e_locked);
            chk({tg, ".err_pulse"}, int'(err_pulse), tbl[i].e_pulse);
            chk({tg, ".expected"},  int'(expected),  tbl[i].e_exp);
            chk({tg, ".err_cnt"},   int'(err_cnt),   tbl[i].e_err);
            chk({tg, ".wrap_cnt"},  int'(wrap_cnt),  tbl[i].e_wrap);
            chk({tg, ".err_cnt_s"}, int'(err_cnt_s), tbl[i].e_err);
        end

        // Five locked errors, relocking in between: small stats saturate at 3.
        for (int i = 0; i < 5; i++) begin
            v = (m_expected() + 5) % c_MOD;
            step(0, 1, 0, v);
            chk("sat.err_pulse", int'(err_pulse), 1);
            step(0, 1, 0, v + 1);
            step(0, 1, 0, v + 2);
            chk("sat.relock", int'(locked), 1);
        end
        chk("sat.err_cnt_s", int'(err_cnt_s), 3);
        chk("sat.err_cnt",   int'(err_cnt),   6);
        check_model("sat");

        // Clear alone on a matching, non-wrapping sample.
        if (m_expected() == 0) step(0, 1, 0, 0);
        step(0, 1, 1, m_expected());
        chk("clr.err_cnt_s",  int'(err_cnt_s),  0);
        chk("clr.err_cnt",    int'(err_cnt),    0);
        chk("clr.wrap_cnt",   int'(wrap_cnt),   0);
        chk("clr.locked",     int'(locked),     1);

        // Clear coincident with a locked error: the error wins.
        v = (m_expected() + 7) % c_MOD;
        step(0, 1, 1, v);
        chk("clr_err.err_cnt",   int'(err_cnt),   1);
        chk("clr_err.err_cnt_s", int'(err_cnt_s), 1);
        chk("clr_err.err_pulse", int'(err_pulse), 1);
        step(0, 1, 0, v + 1);
        step(0, 1, 0, v + 2);
        v = (m_expected() + 5) % c_MOD;
        step(0, 1, 0, v);
        chk("err2.err_cnt", int'(err_cnt), 2);

        // Relock ending at expected = 6, then pause with a bogus value.
        for (int k = 2; k <= 5; k++) step(0, 1, 0, k);
        chk("gate.locked",   int'(locked),   1);
        chk("gate.expected", int'(expected), 6);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 15);
            chk("gate.hold_locked",   int'(locked),    1);
            chk("gate.hold_expected", int'(expected),  6);
            chk("gate.hold_pulse",    int'(err_pulse), 0);
            chk("gate.hold_err",      int'(err_cnt),   2);
        end
        step(0, 1, 0, 6);
        chk("gate.resume_locked", int'(locked),    1);
        chk("gate.resume_pulse",  int'(err_pulse), 0);
        chk("gate.resume_exp",    int'(expected),  7);
        check_model("gate");

        // Reset mid-lock overrides en and clr_stat.
        step(1, 1, 1, 7);
        chk("rst.locked",   int'(locked),    0);
        chk("rst.expected", int'(expected),  0);
        chk("rst.err_cnt",  int'(err_cnt),   0);
        chk("rst.wrap_cnt", int'(wrap_cnt),  0);
        chk("rst.pulse",    int'(err_pulse), 0);
        step(0, 1, 0, 0);
        chk("relock.s1", int'(locked), 0);
        step(0, 1, 0, 1);
        chk("relock.s2", int'(locked), 0);
        step(0, 1, 0, 2);
        chk("relock.s3", int'(locked), 1);
        check_model("relock");

        // Random stream: a counter that pauses with en, with glitches,
        // clears and occasional resets, checked against the model.
        begin
            int src;
            bit e, c, r;
            src = 3;
            for (int i = 0; i < 3000; i++) begin
                r = ($urandom_range(0, 199) == 0);
                e = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 49) == 0);
                v = src;
                if ($urandom_range(0, 19) == 0) v = $urandom_range(0, c_MOD - 1);
                if ($urandom_range(0, 29) == 0) src = $urandom_range(0, c_MOD - 1);
                if (e) src = (v + 1) % c_MOD;
                step(r, e, c, v);
                check_model($sformatf("rnd%0d", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sync_counter_checker
`default_nettype wire
